// File: rtl/pe_sched_pkg.sv
// Shared encodings for the PE job scheduler: FSM states, job modes and response error codes.
package pe_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN1 = 3'd1,
    ST_GAP  = 3'd2,
    ST_RUN2 = 3'd3,
    ST_RESP = 3'd4
  } sched_state_e;

  typedef enum logic [1:0] {
    PE_MODE_NORMAL    = 2'd0,
    PE_MODE_REDUNDANT = 2'd1,
    PE_MODE_DUAL      = 2'd2,
    PE_MODE_ILLEGAL   = 2'd3
  } pe_mode_e;

  typedef enum logic [1:0] {
    RESP_OK       = 2'd0,
    RESP_MISMATCH = 2'd1,
    RESP_TIMEOUT  = 2'd2,
    RESP_ILLEGAL  = 2'd3
  } resp_err_e;

endpackage

// File: rtl/pe_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the index after the last advanced grant.
module rr_arbiter
  import pe_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_idx;
  logic             w_hit;

  always_comb begin
    w_sel = '0;
    w_idx = '0;
    w_hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_hit && req[w_idx]) begin
        w_hit = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  always_comb begin
    grant        = '0;
    grant[w_sel] = w_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance && w_hit) begin
      r_ptr <= (w_sel == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
    end
  end

endmodule

// File: rtl/pe_job_scheduler.sv
// Arbitrates job requests onto one processing element, runs one or two passes with a
// per-pass timeout, and returns the captured result with an error code.
module pe_job_scheduler
  import pe_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int VECTOR_SIZE = 2,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ-1:0][1:0]                 req_mode,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic [$clog2(NUM_REQ)-1:0]              grant_id,
  output logic                                    pe_enable,
  output logic [1:0]                              pe_mode,
  input  logic                                    pe_done,
  input  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]  pe_result,
  output logic                                    resp_valid,
  input  logic                                    resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]              resp_id,
  output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]  resp_data,
  output logic [1:0]                              resp_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_e                           r_state;
  sched_state_e                           w_next;
  pe_mode_e                               r_mode;
  pe_mode_e                               w_gmode;
  resp_err_e                              r_err;
  logic [IDX_W-1:0]                       r_gid;
  logic [IDX_W-1:0]                       w_gidx;
  logic [CNT_W-1:0]                       r_cnt;
  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] r_data;
  logic [NUM_REQ-1:0]                     w_grant;
  logic                                   w_accept;
  logic                                   w_pe_en;
  logic                                   w_timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (w_accept),
    .grant   (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gidx = IDX_W'(i);
    end
  end

  assign w_gmode   = pe_mode_e'(req_mode[w_gidx]);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_pe_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_accept = 1'b1;
          w_next   = (w_gmode == PE_MODE_ILLEGAL) ? ST_RESP : ST_RUN1;
        end
      end
      ST_RUN1: begin
        w_pe_en = 1'b1;
        if (pe_done)        w_next = (r_mode == PE_MODE_REDUNDANT) ? ST_GAP : ST_RESP;
        else if (w_timeout) w_next = ST_RESP;
      end
      // Wait for the PE to drop its done flag so the second pass starts clean
      ST_GAP: begin
        if (!pe_done) w_next = ST_RUN2;
      end
      ST_RUN2: begin
        w_pe_en = 1'b1;
        if (pe_done || w_timeout) w_next = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Accept pulse is masked while reset is held so every output reads zero in reset
  assign req_ready  = (w_accept && rst_n) ? w_grant : '0;
  assign grant_id   = r_gid;
  assign resp_id    = r_gid;
  assign pe_enable  = w_pe_en;
  assign pe_mode    = r_mode;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_data  = r_data;
  assign resp_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gid  <= '0;
      r_mode <= PE_MODE_NORMAL;
      r_err  <= RESP_OK;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      r_cnt <= (w_pe_en && (w_next == r_state)) ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_gid  <= w_gidx;
        r_mode <= w_gmode;
        if (w_gmode == PE_MODE_ILLEGAL) begin
          r_err  <= RESP_ILLEGAL;
          r_data <= '0;
        end else begin
          r_err  <= RESP_OK;
        end
      end else if (w_pe_en && pe_done) begin
        r_data <= pe_result;
        if ((r_state == ST_RUN2) && (pe_result != r_data)) r_err <= RESP_MISMATCH;
      end else if (w_pe_en && w_timeout) begin
        r_err <= RESP_TIMEOUT;
      end
    end
  end

endmodule
